// File: rtl/alu_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding,
// product width and the default BUSY timeout.
package alu_pkg;
   localparam int PROD_W      = 67;
   localparam int TIMEOUT_DEF = 63;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector.
// Ports: valid[1:0] - pending requests (bit i = requester i)
//        last_grant - requester granted most recently
//        grant[1:0] - one-hot grant, all zero when nothing is valid
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // Single requester wins outright; on a tie the one not served last wins.
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto one external multiplier, one operation at
// a time, with a BUSY-phase timeout that returns an error response.
// Ports: clk/rst            - clock, synchronous active-high reset
//        reqN_valid/x/y/ready - operand handshake of requester N
//        rspN_valid/ready   - response handshake of requester N
//        rsp_product/rsp_err - shared response data (held through RESP)
//        mul_start/x/y      - start pulse and held operands to the multiplier
//        mul_done/product   - multiplier completion and result
//        ops_count          - completed responses, wraps at 16 bits
module mul_arbiter
   import alu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [31:0]       req0_x,
   input  logic [31:0]       req0_y,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [31:0]       req1_x,
   input  logic [31:0]       req1_y,
   output logic              req1_ready,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [PROD_W-1:0] rsp_product,
   output logic              rsp_err,
   output logic              mul_start,
   output logic [31:0]       mul_x,
   output logic [31:0]       mul_y,
   input  logic              mul_done,
   input  logic [PROD_W-1:0] mul_product,
   output logic [15:0]       ops_count
);

   // The TIMEOUT-th BUSY cycle is the last one; count starts at 0.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t            state_r, state_s;
   logic [1:0]        grant_s;
   logic              grant_id_r;
   logic              last_grant_r;
   logic [15:0]       cnt_r;
   logic [31:0]       x_r, y_r;
   logic [PROD_W-1:0] product_r;
   logic              err_r;
   logic [15:0]       ops_r;
   logic              start_r, rsp0_v_r, rsp1_v_r;
   logic              accept_s, done_s, timeout_s, consume_s;

   rr_arb2 u_rr_arb2 (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant_r),
      .grant      (grant_s)
   );

   // Next-state decode, combinational ready and handshake qualifiers.
   always_comb begin
      state_s    = state_r;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept_s   = 1'b0;
      done_s     = 1'b0;
      timeout_s  = 1'b0;
      consume_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            req0_ready = grant_s[0];
            req1_ready = grant_s[1];
            accept_s   = grant_s[0] | grant_s[1];
            if (accept_s) state_s = ST_ISSUE;
            else          state_s = ST_IDLE;
         end
         ST_ISSUE: state_s = ST_BUSY;
         ST_BUSY: begin
            // done wins over a timeout in the same cycle
            done_s    = mul_done;
            timeout_s = (cnt_r == TO_LAST) && !mul_done;
            if (done_s || timeout_s) state_s = ST_RESP;
            else                     state_s = ST_BUSY;
         end
         ST_RESP: begin
            // only the granted port's ready can complete the response
            consume_s = grant_id_r ? rsp1_ready : rsp0_ready;
            if (consume_s) state_s = ST_IDLE;
            else           state_s = ST_RESP;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, operand latch, BUSY counter, response capture and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         grant_id_r   <= 1'b0;
         last_grant_r <= 1'b1;
         cnt_r        <= 16'd0;
         x_r          <= 32'd0;
         y_r          <= 32'd0;
         product_r    <= '0;
         err_r        <= 1'b0;
         ops_r        <= 16'd0;
         start_r      <= 1'b0;
         rsp0_v_r     <= 1'b0;
         rsp1_v_r     <= 1'b0;
      end else begin
         state_r  <= state_s;
         // output flags track the state being entered so they align with it
         start_r  <= (state_s == ST_ISSUE);
         rsp0_v_r <= (state_s == ST_RESP) && !grant_id_r;
         rsp1_v_r <= (state_s == ST_RESP) && grant_id_r;
         if (accept_s) begin
            x_r          <= grant_s[1] ? req1_x : req0_x;
            y_r          <= grant_s[1] ? req1_y : req0_y;
            grant_id_r   <= grant_s[1];
            last_grant_r <= grant_s[1];
         end
         if (state_r == ST_BUSY) cnt_r <= cnt_r + 16'd1;
         else                    cnt_r <= 16'd0;
         if (done_s) begin
            product_r <= mul_product;
            err_r     <= 1'b0;
         end else if (timeout_s) begin
            product_r <= '0;
            err_r     <= 1'b1;
         end
         if (consume_s) ops_r <= ops_r + 16'd1;
      end
   end

   assign mul_start   = start_r;
   assign mul_x       = x_r;
   assign mul_y       = y_r;
   assign rsp_product = product_r;
   assign rsp_err     = err_r;
   assign rsp0_valid  = rsp0_v_r;
   assign rsp1_valid  = rsp1_v_r;
   assign ops_count   = ops_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed, table-driven bench for mul_arbiter. The bench plays the
// multiplier (product of the driven operands) and both requesters.
module tb_mul_arbiter;
   localparam int TO = 63;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_x, req0_y, req1_x, req1_y;
   logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [66:0] rsp_product, mul_product;
   logic        rsp_err, mul_start, mul_done;
   logic [31:0] mul_x, mul_y;
   logic [15:0] ops_count;

   int checks = 0;
   int errors = 0;
   int exp_ops = 0;

   typedef struct {
      logic [1:0]  mask;   // which requesters assert valid
      logic        port;   // requester expected to win
      logic [31:0] x;
      logic [31:0] y;
      int          delay;  // BUSY cycle index carrying mul_done (>=TO: never)
      int          hold;   // cycles the response is held before consume
      logic [66:0] prod;
      logic        err;
   } vec_t;

   vec_t vecs[8];

   mul_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_product(rsp_product), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
      .mul_done(mul_done), .mul_product(mul_product),
      .ops_count(ops_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v);
      int cyc;
      int exp_lat;
      logic bad;
      logic [66:0] held;
      logic signed [66:0] p;
      req0_x = v.port ? ~v.x : v.x;
      req0_y = v.port ? ~v.y : v.y;
      req1_x = v.port ? v.x : ~v.x;
      req1_y = v.port ? v.y : ~v.y;
      req0_valid = v.mask[0];
      req1_valid = v.mask[1];
      #1;
      chk("grant", {req1_ready, req0_ready}, v.port ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      chk("issue_start", mul_start, 1'b1);
      chk("issue_x", mul_x, v.x);
      chk("issue_y", mul_y, v.y);
      chk("issue_ready", {req1_ready, req0_ready}, 2'b00);
      @(posedge clk); #1;
      cyc = 0;
      bad = 1'b0;
      while (!(rsp0_valid || rsp1_valid) && cyc < 200) begin
         if (mul_start || req0_ready || req1_ready || mul_x !== v.x || mul_y !== v.y) bad = 1'b1;
         p = $signed(mul_x) * $signed(mul_y);
         mul_product = p;
         mul_done = (cyc == v.delay);
         @(posedge clk); #1;
         cyc++;
      end
      mul_done = 1'b0;
      mul_product = 67'd0;
      exp_lat = (v.delay < TO) ? v.delay + 1 : TO;
      chk("busy_side", bad, 1'b0);
      chk("latency", cyc, exp_lat);
      chk("rsp_valid", {rsp1_valid, rsp0_valid}, v.port ? 2'b10 : 2'b01);
      chk("rsp_product", rsp_product, v.prod);
      chk("rsp_err", rsp_err, v.err);
      held = rsp_product;
      bad = 1'b0;
      for (int i = 0; i < v.hold; i++) begin
         // only the wrong port says ready; it must be ignored
         rsp0_ready = v.port;
         rsp1_ready = !v.port;
         @(posedge clk); #1;
         if ({rsp1_valid, rsp0_valid} !== (v.port ? 2'b10 : 2'b01) || rsp_product !== held ||
             rsp_err !== v.err || req0_ready || req1_ready || mul_start) bad = 1'b1;
      end
      chk("hold_stable", bad, 1'b0);
      rsp0_ready = !v.port;
      rsp1_ready = v.port;
      @(posedge clk); #1;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      exp_ops++;
      chk("ops_count", ops_count, exp_ops[15:0]);
      chk("rsp_cleared", {rsp1_valid, rsp0_valid}, 2'b00);
   endtask

   initial begin
      vec_t post;
      logic bad;
      vecs[0] = '{2'b11, 1'b0, 32'd172, 32'd172, 20, 10, 67'd29584, 1'b0};
      vecs[1] = '{2'b11, 1'b1, 32'hFFFF_FFFD, 32'd5, 0, 0, 67'h7_FFFF_FFFF_FFFF_FFF1, 1'b0};
      vecs[2] = '{2'b11, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 3, 2, 67'h0_3FFF_FFFF_0000_0001, 1'b0};
      vecs[3] = '{2'b10, 1'b1, 32'h8000_0000, 32'h8000_0000, 5, 1, 67'h0_4000_0000_0000_0000, 1'b0};
      vecs[4] = '{2'b01, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 67'h7_C000_0000_8000_0000, 1'b0};
      vecs[5] = '{2'b10, 1'b1, 32'd7, 32'hFFFF_FFFA, 1000, 2, 67'd0, 1'b1};
      vecs[6] = '{2'b01, 1'b0, 32'd7, 32'hFFFF_FFFA, TO - 1, 0, 67'h7_FFFF_FFFF_FFFF_FFD6, 1'b0};
      vecs[7] = '{2'b11, 1'b1, 32'd0, 32'd12345, 2, 0, 67'd0, 1'b0};

      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_x = 32'd0; req0_y = 32'd0; req1_x = 32'd0; req1_y = 32'd0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      mul_done = 1'b0; mul_product = 67'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_flags", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, mul_start}, 6'd0);
      chk("rst_product", rsp_product, 67'd0);
      chk("rst_mul_x", mul_x, 32'd0);
      chk("rst_mul_y", mul_y, 32'd0);
      chk("rst_ops", ops_count, 16'd0);

      for (int i = 0; i < 8; i++) run_op(vecs[i]);

      // reset in the middle of BUSY drops the operation
      req0_x = 32'd5; req0_y = 32'd6; req0_valid = 1'b1;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_valid", {rsp1_valid, rsp0_valid, mul_start}, 3'd0);
      chk("mid_rst_ops", ops_count, 16'd0);
      chk("mid_rst_product", rsp_product, 67'd0);
      chk("mid_rst_mul_x", mul_x, 32'd0);
      req1_valid = 1'b1;
      #1;
      chk("mid_rst_idle_ready", {req1_ready, req0_ready}, 2'b10);
      req1_valid = 1'b0;
      // a stray mul_done in IDLE must not produce a response
      mul_done = 1'b1; mul_product = 67'h55;
      @(posedge clk); #1;
      mul_done = 1'b0; mul_product = 67'd0;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (rsp0_valid || rsp1_valid || mul_start || rsp_product !== 67'd0) bad = 1'b1;
         @(posedge clk); #1;
      end
      chk("stray_done", bad, 1'b0);
      exp_ops = 0;
      post = '{2'b11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1, 67'd1, 1'b0};
      run_op(post);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 63, is the maximum number of BUSY cycles to wait for mul_done before aborting.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid/req1_valid  input  1 each  requester i has an operand pair pending.
REQ-005 req0_x/req0_y, req1_x/req1_y  input  32 each  signed two's-complement operands of requester i.
REQ-006 req0_ready/req1_ready  output  1 each  requester i's operands are accepted this cycle.
REQ-007 rsp0_valid/rsp1_valid  output  1 each  result for requester i is held on rsp_product/rsp_err.
REQ-008 rsp0_ready/rsp1_ready  input  1 each  requester i consumes the result this cycle.
REQ-009 rsp_product  output  67  signed product, sign-extended, shared by both response ports.
REQ-010 rsp_err  output  1  result was aborted by timeout.
REQ-011 mul_start  output  1  one-cycle start pulse to the multiplier unit.
REQ-012 mul_x/mul_y  output  32 each  latched operands driven to the multiplier.
REQ-013 mul_done  input  1  multiplier result is valid this cycle.
REQ-014 mul_product  input  67  multiplier result.
REQ-015 ops_count  output  16  number of completed responses, wraps modulo 2^16.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, BUSY and RESP, one-hot or binary encoded.
REQ-017 In IDLE with exactly one reqi_valid, reqi_ready SHALL be asserted combinationally in that cycle.
REQ-018 In IDLE with both valid, the grant SHALL go to the requester that is not last_grant (round-robin).
REQ-019 On acceptance (valid&ready), operands and grant id SHALL latch, last_grant SHALL update, and the state SHALL become ISSUE.
REQ-020 Both req_ready outputs SHALL be 0 in every state other than IDLE.
REQ-021 ISSUE SHALL last exactly one cycle with mul_start=1, then go to BUSY; mul_start SHALL be 0 in all other states.
REQ-022 mul_x/mul_y SHALL hold the latched operands stable from ISSUE through the end of BUSY.
REQ-023 BUSY SHALL count cycles from 0; on mul_done, mul_product SHALL be captured, rsp_err=0, state SHALL become RESP.
REQ-024 If the count reaches TIMEOUT without mul_done, rsp_product SHALL be 0, rsp_err=1, state SHALL become RESP.
REQ-025 mul_done and timeout in the same cycle SHALL resolve as done (REQ-023).
REQ-026 mul_done outside BUSY SHALL be ignored.
REQ-027 In RESP, only the granted rspi_valid SHALL be 1; rsp_product/rsp_err SHALL hold stable until rspi_ready.
REQ-028 On rspi_valid&rspi_ready, ops_count SHALL increment (wrapping from 0xFFFF to 0) and the state SHALL become IDLE.
REQ-029 rspi_ready on the non-granted port SHALL be ignored.
REQ-030 Minimum latency from acceptance to rsp_valid SHALL be 3 cycles, for mul_done on the first BUSY cycle.
REQ-031 Only one operation SHALL be outstanding at a time; new requests wait in IDLE.

Reset
REQ-032 While rst=1 at a clock edge: state=IDLE, last_grant=1 (requester 0 wins first tie), count=0, ops_count=0, rsp_product=0, rsp_err=0, latched operands=0.
REQ-033 After reset, all outputs SHALL be 0 except those driven combinationally by REQ-017.
REQ-034 Reset mid-operation SHALL discard the outstanding request without a response; the multiplier is reset by the same rst.

Structure
REQ-035 State encodings, the 67-bit product width and the default TIMEOUT SHALL live in shared package alu_pkg.
REQ-036 Round-robin selection SHALL be a sub-module rr_arb2 (inputs: two valids and last_grant; outputs: grant one-hot).

Verification
REQ-037 req0 172x172 alone, mul_done after 20 cycles -> rsp0_valid, rsp_product=29584, rsp_err=0, ops_count=1.
REQ-038 req0 and req1 valid together from reset -> req0 served first, then req1; next tie -> req0 again.
REQ-039 req1 x=-3, y=5 -> rsp_product=67'h7_FFFF_FFFF_FFFF_FFF1 (-15), only rsp1_valid asserted.
REQ-040 mul_done never asserted -> rsp_err=1, rsp_product=0 exactly TIMEOUT cycles after BUSY entry; mul_done on that same cycle -> rsp_err=0.
REQ-041 rsp0_ready held low 10 cycles -> rsp0_valid and data stable, req_ready stays 0, no second mul_start.
REQ-042 rst pulsed during BUSY -> next cycle IDLE, no response, ops_count=0; the next request completes normally.
